// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and
// request-decode helpers used at accept time.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      MERGE = 3'd2,
      WRITE = 3'd3,
      RESP  = 3'd4
   } lsu_state_t;

   // Loads know the unsigned variants; stores only know B/H/W.
   function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
      logic ill;
      if (we) begin
         ill = !((f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W));
      end else begin
         ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      return ill;
   endfunction

   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
      logic mis;
      case (f3)
         F3_H, F3_HU: mis = off[0];
         F3_W:        mis = (off != 2'b00);
         default:     mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: load extraction with sign/zero extension,
// and the read-modify-write merge used for sub-word stores.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] rdata,
   output logic [31:0] merged
);

   function automatic logic [31:0] extract_word(input logic [31:0] w,
                                                input logic [1:0]  off,
                                                input logic [2:0]  f3);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = 8'(w >> {off, 3'b000});
      h = off[1] ? w[31:16] : w[15:0];
      case (f3)
         F3_B:    r = {{24{b[7]}}, b};
         F3_H:    r = {{16{h[15]}}, h};
         F3_W:    r = w;
         F3_BU:   r = {24'h000000, b};
         F3_HU:   r = {16'h0000, h};
         default: r = 32'h0000_0000;
      endcase
      return r;
   endfunction

   // Untouched lanes keep the old memory contents.
   function automatic logic [31:0] merge_word(input logic [31:0] w,
                                              input logic [31:0] wd,
                                              input logic [1:0]  off,
                                              input logic [2:0]  f3);
      logic [31:0] m;
      m = w;
      case (f3)
         F3_B: m[{off, 3'b000} +: 8] = wd[7:0];
         F3_H: begin
            if (off[1]) begin
               m[31:16] = wd[15:0];
            end else begin
               m[15:0] = wd[15:0];
            end
         end
         F3_W:    m = wd;
         default: m = w;
      endcase
      return m;
   endfunction

   assign rdata  = extract_word(word, offset, funct3);
   assign merged = merge_word(word, wdata, offset, funct3);

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit for a word-wide data memory without byte enables; sub-word
// stores are performed as read-modify-write through the MERGE state.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_BYTES = 256
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   input  logic [31:0] mem_rdata
);

   lsu_state_t  state_r;
   lsu_state_t  state_s;
   logic [2:0]  f3_r;
   logic [1:0]  off_r;
   logic [31:0] wdata_r;
   logic        accept_s;
   logic        err_s;
   logic [31:0] align_rdata_s;
   logic [31:0] merged_s;

   assign req_ready = (state_r == IDLE) && !rst;
   assign mem_we    = (state_r == WRITE) && !rst;
   assign accept_s  = req_valid && req_ready;
   assign err_s     = f3_illegal(req_we, req_funct3)
                   || misaligned(req_funct3, req_addr[1:0])
                   || (req_addr >= MEM_BYTES);

   lsu_align u_align (
      .word   (mem_rdata),
      .wdata  (wdata_r),
      .offset (off_r),
      .funct3 (f3_r),
      .rdata  (align_rdata_s),
      .merged (merged_s)
   );

   // Next-state selection
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (!accept_s) begin
               state_s = IDLE;
            end else if (err_s) begin
               state_s = RESP;
            end else if (!req_we) begin
               state_s = LOAD;
            end else if (req_funct3 == F3_W) begin
               state_s = WRITE;
            end else begin
               state_s = MERGE;
            end
         end
         LOAD:    state_s = RESP;
         MERGE:   state_s = WRITE;
         WRITE:   state_s = RESP;
         RESP:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State, request capture and registered response/memory outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         f3_r       <= 3'b000;
         off_r      <= 2'b00;
         wdata_r    <= 32'h0000_0000;
         resp_valid <= 1'b0;
         resp_rdata <= 32'h0000_0000;
         resp_err   <= 1'b0;
         mem_addr   <= 32'h0000_0000;
         mem_wdata  <= 32'h0000_0000;
      end else begin
         state_r    <= state_s;
         resp_valid <= (state_s == RESP);
         // Only the error path goes straight from IDLE to RESP.
         resp_err   <= (state_r == IDLE) && (state_s == RESP);
         resp_rdata <= (state_r == LOAD) ? align_rdata_s : 32'h0000_0000;
         if (accept_s) begin
            f3_r      <= req_funct3;
            off_r     <= req_addr[1:0];
            wdata_r   <= req_wdata;
            mem_addr  <= {req_addr[31:2], 2'b00};
            mem_wdata <= req_wdata;
         end else if (state_r == MERGE) begin
            mem_wdata <= merged_s;
         end else begin
            mem_wdata <= mem_wdata;
         end
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a small word memory
// model attached to the memory port.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic [31:0] mem_rdata;

   logic [31:0] mem [0:63];
   int          total = 0;
   int          bad = 0;
   int          we_cnt = 0;

   load_store_unit #(.MEM_BYTES(256)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_we     (mem_we),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr[7:2]];

   always @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr[7:2]] <= mem_wdata;
         we_cnt <= we_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One request: latency counted in cycles after the accept edge,
   // write position and write data captured from the memory port.
   task automatic run_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int exp_lat, input logic [31:0] exp_rd, input logic exp_err,
                          input int exp_we_at, input logic [31:0] exp_mw);
      int n;
      int we_at;
      int c0;
      logic [31:0] mw;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      check({tag, ".ready"}, 32'(req_ready), 32'd1);
      c0 = we_cnt; we_at = 0; mw = 32'h0;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      n = 1;
      while (n < 12) begin
         if (mem_we) begin
            we_at = n;
            mw = mem_wdata;
         end
         if (resp_valid) break;
         @(negedge clk);
         n++;
      end
      check({tag, ".lat"}, 32'(n), 32'(exp_lat));
      check({tag, ".rdata"}, resp_rdata, exp_rd);
      check({tag, ".err"}, 32'(resp_err), 32'(exp_err));
      check({tag, ".we_at"}, 32'(we_at), 32'(exp_we_at));
      check({tag, ".mwdata"}, mw, exp_mw);
      check({tag, ".wecnt"}, 32'(we_cnt - c0), (exp_we_at != 0) ? 32'd1 : 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0000;
      mem[1]  = 32'hCAFE_F00D;
      mem[4]  = 32'hDEAD_BEEF;
      mem[8]  = 32'h1122_3344;
      mem[63] = 32'h0BAD_F00D;
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
      req_addr = 32'h0; req_wdata = 32'h0;
      repeat (3) @(negedge clk);
      check("rst.resp_valid", 32'(resp_valid), 32'd0);
      check("rst.resp_rdata", resp_rdata, 32'h0);
      check("rst.resp_err", 32'(resp_err), 32'd0);
      check("rst.mem_addr", mem_addr, 32'h0);
      check("rst.mem_wdata", mem_wdata, 32'h0);
      check("rst.mem_we", 32'(mem_we), 32'd0);
      check("rst.ready", 32'(req_ready), 32'd0);
      rst = 1'b0;
      #1;
      check("rst.ready_after", 32'(req_ready), 32'd1);

      run_req("lw10",  1'b0, 3'b010, 32'h10, 32'h0, 2, 32'hDEAD_BEEF, 1'b0, 0, 32'h0);
      run_req("lb13",  1'b0, 3'b000, 32'h13, 32'h0, 2, 32'hFFFF_FFDE, 1'b0, 0, 32'h0);
      run_req("lbu13", 1'b0, 3'b100, 32'h13, 32'h0, 2, 32'h0000_00DE, 1'b0, 0, 32'h0);
      run_req("lhu12", 1'b0, 3'b101, 32'h12, 32'h0, 2, 32'h0000_DEAD, 1'b0, 0, 32'h0);
      run_req("lh10",  1'b0, 3'b001, 32'h10, 32'h0, 2, 32'hFFFF_BEEF, 1'b0, 0, 32'h0);
      run_req("sb11",  1'b1, 3'b000, 32'h11, 32'h0000_00AA, 3, 32'h0, 1'b0, 2, 32'hDEAD_AAEF);
      run_req("lw10b", 1'b0, 3'b010, 32'h10, 32'h0, 2, 32'hDEAD_AAEF, 1'b0, 0, 32'h0);
      run_req("sh06",  1'b1, 3'b001, 32'h06, 32'h0000_1234, 3, 32'h0, 1'b0, 2, 32'h1234_F00D);
      run_req("lw04",  1'b0, 3'b010, 32'h04, 32'h0, 2, 32'h1234_F00D, 1'b0, 0, 32'h0);
      run_req("sw08",  1'b1, 3'b010, 32'h08, 32'hA5A5_A5A5, 2, 32'h0, 1'b0, 1, 32'hA5A5_A5A5);
      run_req("lw08",  1'b0, 3'b010, 32'h08, 32'h0, 2, 32'hA5A5_A5A5, 1'b0, 0, 32'h0);
      run_req("lwfc",  1'b0, 3'b010, 32'hFC, 32'h0, 2, 32'h0BAD_F00D, 1'b0, 0, 32'h0);
      run_req("e_lh01",  1'b0, 3'b001, 32'h01,  32'h0, 1, 32'h0, 1'b1, 0, 32'h0);
      run_req("e_sw102", 1'b1, 3'b010, 32'h102, 32'h0, 1, 32'h0, 1'b1, 0, 32'h0);
      run_req("e_ld011", 1'b0, 3'b011, 32'h00,  32'h0, 1, 32'h0, 1'b1, 0, 32'h0);
      run_req("e_st100", 1'b1, 3'b100, 32'h00,  32'hFF, 1, 32'h0, 1'b1, 0, 32'h0);
      run_req("e_lb100", 1'b0, 3'b000, 32'h100, 32'h0, 1, 32'h0, 1'b1, 0, 32'h0);
      check("e.mem0", mem[0], 32'h0);

      // Reset while the SH at 0x20 sits in MERGE
      mem[8] = 32'h1122_3344;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h20; req_wdata = 32'h0000_BEEF;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      check("rm.mem_we", 32'(mem_we), 32'd0);
      check("rm.resp_valid", 32'(resp_valid), 32'd0);
      check("rm.resp_rdata", resp_rdata, 32'h0);
      check("rm.resp_err", 32'(resp_err), 32'd0);
      check("rm.mem_addr", mem_addr, 32'h0);
      check("rm.mem_wdata", mem_wdata, 32'h0);
      rst = 1'b0;
      #1;
      check("rm.ready", 32'(req_ready), 32'd1);
      repeat (3) @(negedge clk);
      check("rm.no_resp", 32'(resp_valid), 32'd0);
      check("rm.word8", mem[8], 32'h1122_3344);

      // Reset asserted while an SW is in WRITE must block the write
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h7777_7777;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0; rst = 1'b1;
      #1;
      check("rw.mem_we", 32'(mem_we), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("rw.word8", mem[8], 32'h1122_3344);

      // Back-to-back: SW 0x55 at 0x04 then LW at 0x04 with req_valid held
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h04; req_wdata = 32'h0000_0055;
      @(posedge clk);
      @(negedge clk);
      req_we = 1'b0; req_wdata = 32'h0;
      check("bb.ready_write", 32'(req_ready), 32'd0);
      @(negedge clk);
      check("bb.resp1", 32'(resp_valid), 32'd1);
      check("bb.ready_resp", 32'(req_ready), 32'd0);
      @(negedge clk);
      check("bb.ready_idle", 32'(req_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check("bb.load_busy", 32'(resp_valid), 32'd0);
      @(negedge clk);
      check("bb.resp2", 32'(resp_valid), 32'd1);
      check("bb.rdata", resp_rdata, 32'h0000_0055);
      check("bb.err", 32'(resp_err), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
